// File: rtl/byteswap_pkg.sv
// Shared types and constants for the byteswap burst scheduler.
package byteswap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int AXI_4K_BYTES = 4096;
    localparam int ARLEN_W      = 8;
    localparam int CNT_W        = 32;

endpackage

// File: rtl/byteswap_burst_gen.sv
// One address/remaining generator: splits a run into bursts limited by
// maximum burst length and 4 KiB page boundaries.
import byteswap_pkg::*;

module byteswap_burst_gen #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  size,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  rem,
    output logic [ARLEN_W-1:0] len
);

    localparam int BPB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPB - 1);

    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W-1:0]  next_rem;
    logic [CNT_W-1:0]  cur_beats;
    logic [CNT_W-1:0]  next_beats;

    function automatic logic [CNT_W-1:0] burst_beats(input logic [11:0] page_ofs,
                                                     input logic [CNT_W-1:0] left);
        logic [CNT_W-1:0] to_4k;
        logic [CNT_W-1:0] beats;
        to_4k = (CNT_W'(AXI_4K_BYTES) - CNT_W'(page_ofs)) / CNT_W'(BPB);
        beats = left;
        if (beats > CNT_W'(MAX_BURST)) beats = CNT_W'(MAX_BURST);
        if (beats > to_4k) beats = to_4k;
        return beats;
    endfunction

    // The length for the burst after this one is precomputed so len is a flop
    // that is already valid the cycle after a handshake.
    always_comb begin
        cur_beats = CNT_W'(len) + 1'b1;
        next_addr = addr;
        next_rem  = rem;
        if (load) begin
            next_addr = base & ALIGN_MASK;
            next_rem  = size;
        end else if (advance) begin
            next_addr = addr + ADDR_W'(cur_beats) * ADDR_W'(BPB);
            next_rem  = rem - cur_beats;
        end
        next_beats = burst_beats(next_addr[11:0], next_rem);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            rem  <= '0;
            len  <= '0;
        end else begin
            addr <= next_addr;
            rem  <= next_rem;
            len  <= (next_beats == '0) ? '0 : ARLEN_W'(next_beats - 1'b1);
        end
    end

endmodule

// File: rtl/byteswap_burst_sched.sv
// Burst scheduler for one in-place byteswap run: issues read bursts, the
// matching write bursts once their data has returned, and counts responses.
import byteswap_pkg::*;

module byteswap_burst_sched #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 32,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_MAX_BURST_BEATS = 64,
    parameter int C_MAX_OUTSTANDING = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [C_ADDR_WIDTH-1:0]      gmem_ptr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size,
    output logic                         rd_cmd_valid,
    input  logic                         rd_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]      rd_cmd_addr,
    output logic [ARLEN_W-1:0]           rd_cmd_len,
    output logic                         wr_cmd_valid,
    input  logic                         wr_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]      wr_cmd_addr,
    output logic [ARLEN_W-1:0]           wr_cmd_len,
    input  logic                         rd_burst_done,
    input  logic                         wr_resp_valid,
    input  logic                         wr_resp_err,
    output logic                         err
);

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(C_MAX_OUTSTANDING);

    state_t state;

    logic [CNT_W-1:0] rd_outstanding, rd_completed, wr_issued, b_cnt;
    logic [CNT_W-1:0] rd_rem, wr_rem, size_in;
    logic [CNT_W-1:0] rd_rem_after, wr_rem_after;
    logic [CNT_W-1:0] rd_out_next, rd_comp_next, wr_iss_next, b_cnt_next;
    logic             start_accept, in_run, rd_fire, wr_fire, rd_done_hit, b_hit;
    logic             run_complete;

    assign size_in  = CNT_W'(xfer_size);
    assign ap_ready = ap_done;

    byteswap_burst_gen #(
        .ADDR_W   (C_ADDR_WIDTH),
        .DATA_W   (C_DATA_WIDTH),
        .MAX_BURST(C_MAX_BURST_BEATS)
    ) u_rd_gen (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .load   (start_accept),
        .base   (gmem_ptr),
        .size   (size_in),
        .advance(rd_fire),
        .addr   (rd_cmd_addr),
        .rem    (rd_rem),
        .len    (rd_cmd_len)
    );

    byteswap_burst_gen #(
        .ADDR_W   (C_ADDR_WIDTH),
        .DATA_W   (C_DATA_WIDTH),
        .MAX_BURST(C_MAX_BURST_BEATS)
    ) u_wr_gen (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .load   (start_accept),
        .base   (gmem_ptr),
        .size   (size_in),
        .advance(wr_fire),
        .addr   (wr_cmd_addr),
        .rem    (wr_rem),
        .len    (wr_cmd_len)
    );

    // Next-cycle view of every counter, so valids and completion are decided
    // one cycle early and still come out of flops.
    always_comb begin
        start_accept = (state == ST_IDLE) && ap_start;
        in_run       = (state == ST_RUN);
        rd_fire      = rd_cmd_valid && rd_cmd_ready;
        wr_fire      = wr_cmd_valid && wr_cmd_ready;
        rd_done_hit  = in_run && rd_burst_done;
        b_hit        = in_run && wr_resp_valid;
        rd_rem_after = rd_fire ? rd_rem - (CNT_W'(rd_cmd_len) + 1'b1) : rd_rem;
        wr_rem_after = wr_fire ? wr_rem - (CNT_W'(wr_cmd_len) + 1'b1) : wr_rem;
        rd_out_next  = rd_outstanding + CNT_W'(rd_fire) - CNT_W'(rd_done_hit);
        rd_comp_next = rd_completed + CNT_W'(rd_done_hit);
        wr_iss_next  = wr_issued + CNT_W'(wr_fire);
        b_cnt_next   = b_cnt + CNT_W'(b_hit);
        run_complete = (rd_rem_after == '0) && (wr_rem_after == '0) &&
                       (b_cnt_next == wr_iss_next);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state          <= ST_IDLE;
            ap_idle        <= 1'b1;
            ap_done        <= 1'b0;
            rd_cmd_valid   <= 1'b0;
            wr_cmd_valid   <= 1'b0;
            err            <= 1'b0;
            rd_outstanding <= '0;
            rd_completed   <= '0;
            wr_issued      <= '0;
            b_cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        state          <= ST_RUN;
                        ap_idle        <= 1'b0;
                        err            <= 1'b0;
                        rd_outstanding <= '0;
                        rd_completed   <= '0;
                        wr_issued      <= '0;
                        b_cnt          <= '0;
                    end
                end
                ST_RUN: begin
                    rd_outstanding <= rd_out_next;
                    rd_completed   <= rd_comp_next;
                    wr_issued      <= wr_iss_next;
                    b_cnt          <= b_cnt_next;
                    if (b_hit && wr_resp_err) err <= 1'b1;
                    if (run_complete) begin
                        state        <= ST_DONE;
                        ap_done      <= 1'b1;
                        rd_cmd_valid <= 1'b0;
                        wr_cmd_valid <= 1'b0;
                    end else begin
                        // A write may only go out once its read data is back.
                        rd_cmd_valid <= (rd_rem_after != '0) && (rd_out_next < MAX_OUT);
                        wr_cmd_valid <= (wr_rem_after != '0) && (wr_iss_next < rd_comp_next);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state        <= ST_IDLE;
                    ap_idle      <= 1'b1;
                    ap_done      <= 1'b0;
                    rd_cmd_valid <= 1'b0;
                    wr_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byteswap_burst_sched.sv
// Scoreboard bench for byteswap_burst_sched: expected bursts are queued at
// start and popped as the scheduler issues commands.
module tb_byteswap_burst_sched;

    localparam int MAX_OUT = 2;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } cmd_t;

    logic        ap_clk, ap_rst_n, ap_start;
    logic        ap_idle, ap_done, ap_ready, err;
    logic [63:0] gmem_ptr;
    logic [31:0] xfer_size;
    logic        rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready;
    logic [63:0] rd_cmd_addr, wr_cmd_addr;
    logic [7:0]  rd_cmd_len, wr_cmd_len;
    logic        rd_burst_done, wr_resp_valid, wr_resp_err;

    cmd_t exp_rd[$];
    cmd_t exp_wr[$];
    cmd_t mon_cmd;
    int   total = 0, bad = 0, cyc = 0, last_resp_cyc = 0;
    int   rd_pending = 0, wr_pending = 0, rd_hs = 0, wr_hs = 0, rd_done_cnt = 0;
    bit   bp = 0, auto_rd = 1, one_done = 0, hold_ready = 0, inject_err = 0;

    byteswap_burst_sched #(
        .C_ADDR_WIDTH     (64),
        .C_DATA_WIDTH     (32),
        .C_XFER_SIZE_WIDTH(32),
        .C_MAX_BURST_BEATS(64),
        .C_MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .ap_idle      (ap_idle),
        .ap_done      (ap_done),
        .ap_ready     (ap_ready),
        .gmem_ptr     (gmem_ptr),
        .xfer_size    (xfer_size),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_ready (rd_cmd_ready),
        .rd_cmd_addr  (rd_cmd_addr),
        .rd_cmd_len   (rd_cmd_len),
        .wr_cmd_valid (wr_cmd_valid),
        .wr_cmd_ready (wr_cmd_ready),
        .wr_cmd_addr  (wr_cmd_addr),
        .wr_cmd_len   (wr_cmd_len),
        .rd_burst_done(rd_burst_done),
        .wr_resp_valid(wr_resp_valid),
        .wr_resp_err  (wr_resp_err),
        .err          (err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Memory-side responder: ready, read completion and write responses.
    initial begin
        rd_cmd_ready  = 1'b0;
        wr_cmd_ready  = 1'b0;
        rd_burst_done = 1'b0;
        wr_resp_valid = 1'b0;
        wr_resp_err   = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            rd_cmd_ready  = hold_ready ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            wr_cmd_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_burst_done = 1'b0;
            if (rd_pending > 0 && (auto_rd || one_done) && (!bp || $urandom_range(0, 2) == 0)) begin
                rd_burst_done = 1'b1;
                rd_pending--;
                one_done = 0;
            end
            wr_resp_valid = 1'b0;
            wr_resp_err   = 1'b0;
            if (wr_pending > 0 && (!bp || $urandom_range(0, 2) == 0)) begin
                wr_resp_valid = 1'b1;
                wr_pending--;
                if (inject_err) begin
                    wr_resp_err = 1'b1;
                    inject_err  = 0;
                end
            end
        end
    end

    // Command monitor: every handshake is checked against the scoreboard.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (rd_burst_done) rd_done_cnt++;
            if (wr_resp_valid) last_resp_cyc = cyc;
            if (rd_cmd_valid && rd_cmd_ready) begin
                rd_hs++;
                rd_pending++;
                if (exp_rd.size() == 0) checkOutput("rd_unexpected", 64'd1, 64'd0);
                else begin
                    mon_cmd = exp_rd.pop_front();
                    checkOutput("rd_addr", rd_cmd_addr, mon_cmd.addr);
                    checkOutput("rd_len", 64'(rd_cmd_len), 64'(mon_cmd.len));
                end
            end
            if (wr_cmd_valid && wr_cmd_ready) begin
                checkOutput("wr_after_rd", 64'(wr_hs < rd_done_cnt), 64'd1);
                wr_hs++;
                wr_pending++;
                if (exp_wr.size() == 0) checkOutput("wr_unexpected", 64'd1, 64'd0);
                else begin
                    mon_cmd = exp_wr.pop_front();
                    checkOutput("wr_addr", wr_cmd_addr, mon_cmd.addr);
                    checkOutput("wr_len", 64'(wr_cmd_len), 64'(mon_cmd.len));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] ptr, input logic [31:0] size);
        logic [63:0] a;
        logic [31:0] rem, to4k, b;
        cmd_t        c;
        bit          seen;
        a   = ptr & ~64'h3;
        rem = size;
        while (rem != 0) begin
            to4k = (32'd4096 - {20'd0, a[11:0]}) / 32'd4;
            b = rem;
            if (b > 32'd64) b = 32'd64;
            if (b > to4k) b = to4k;
            c.addr = a;
            c.len  = 8'(b - 1);
            exp_rd.push_back(c);
            exp_wr.push_back(c);
            a   = a + 64'(b) * 64'd4;
            rem = rem - b;
        end
        rd_hs = 0;
        wr_hs = 0;
        rd_done_cnt = 0;
        @(posedge ap_clk);
        #1;
        ap_start  = 1'b1;
        gmem_ptr  = ptr;
        xfer_size = size;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        @(negedge ap_clk);
        checkOutput("idle_drop", 64'(ap_idle), 64'd0);
        checkOutput("err_clear", 64'(err), 64'd0);
        seen = rd_cmd_valid;
        @(negedge ap_clk);
        if (size == 0) checkOutput("zero_done", 64'(ap_done), 64'd1);
        else begin
            seen = seen | rd_cmd_valid;
            checkOutput("first_rd_valid", 64'(seen), 64'd1);
        end
    endtask

    task automatic finishRun(input bit exp_err);
        bit got;
        got = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                got = 1;
                break;
            end
        end
        checkOutput("done_seen", 64'(got), 64'd1);
        if (got) begin
            checkOutput("ready", 64'(ap_ready), 64'd1);
            checkOutput("err_at_done", 64'(err), 64'(exp_err));
            checkOutput("done_latency", 64'(cyc - last_resp_cyc), 64'd1);
            @(negedge ap_clk);
            checkOutput("done_pulse", 64'(ap_done), 64'd0);
            checkOutput("idle_back", 64'(ap_idle), 64'd1);
        end
        checkOutput("rd_left", 64'(exp_rd.size()), 64'd0);
        checkOutput("wr_left", 64'(exp_wr.size()), 64'd0);
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        ap_start  = 1'b0;
        gmem_ptr  = '0;
        xfer_size = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checkOutput("rst_idle", 64'(ap_idle), 64'd1);
        checkOutput("rst_done", 64'(ap_done), 64'd0);
        checkOutput("rst_rd_valid", 64'(rd_cmd_valid), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        $display("[TB] single burst, page crossing, max-burst split");
        applyStimulus(64'h1000, 32'd16);  finishRun(0);
        applyStimulus(64'h1FF0, 32'd8);   finishRun(0);
        applyStimulus(64'h0, 32'd130);    finishRun(0);

        $display("[TB] misaligned pointer and long run with backpressure");
        bp = 1;
        applyStimulus(64'h0FFE, 32'd5);   finishRun(0);
        applyStimulus(64'h0F80, 32'd300); finishRun(0);
        bp = 0;

        $display("[TB] outstanding limit");
        auto_rd = 0;
        applyStimulus(64'h0, 32'd256);
        repeat (20) @(negedge ap_clk);
        checkOutput("out_rd_count", 64'(rd_hs), 64'd2);
        checkOutput("out_wr_count", 64'(wr_hs), 64'd0);
        one_done = 1;
        repeat (10) @(negedge ap_clk);
        checkOutput("out_rd_after", 64'(rd_hs), 64'd3);
        checkOutput("out_wr_after", 64'(wr_hs), 64'd1);
        auto_rd = 1;
        finishRun(0);

        $display("[TB] zero size and start while busy");
        applyStimulus(64'h0, 32'd0);
        @(negedge ap_clk);
        checkOutput("zero_idle", 64'(ap_idle), 64'd1);
        checkOutput("zero_pulse", 64'(ap_done), 64'd0);
        hold_ready = 1;
        applyStimulus(64'h2000, 32'd40);
        @(posedge ap_clk);
        #1;
        ap_start  = 1'b1;
        gmem_ptr  = 64'h9000;
        xfer_size = 32'd4;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        @(negedge ap_clk);
        checkOutput("busy_ignore", 64'(ap_idle), 64'd0);
        hold_ready = 0;
        finishRun(0);

        $display("[TB] write error response");
        inject_err = 1;
        applyStimulus(64'h4000, 32'd100); finishRun(1);
        applyStimulus(64'h4000, 32'd20);  finishRun(0);

        $display("[TB] reset mid-run");
        hold_ready = 1;
        applyStimulus(64'h3000, 32'd16);
        checkOutput("valid_pre_rst", 64'(rd_cmd_valid), 64'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(rd_cmd_valid), 64'd0);
        checkOutput("mid_rst_addr", rd_cmd_addr, 64'd0);
        checkOutput("mid_rst_len", 64'(rd_cmd_len), 64'd0);
        checkOutput("mid_rst_idle", 64'(ap_idle), 64'd1);
        checkOutput("mid_rst_wvalid", 64'(wr_cmd_valid), 64'd0);
        exp_rd.delete();
        exp_wr.delete();
        rd_pending = 0;
        wr_pending = 0;
        hold_ready = 0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        applyStimulus(64'h1000, 32'd16);  finishRun(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
